uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx_serializer.sv | 54 +++++
 rtl/uart_tx.sv | 98 +++++++++
 tb/tb_uart_tx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the receive path)
// and parity-type constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b011,
      PARITY = 3'b010,
      STOP   = 3'b110
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      input  TX_OUT, Busy
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      output TX_OUT, Busy
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// Capture register plus LSB-first shift register and bit counter; the FSM
// drives load/shift and watches the last-bit flag.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  bit_out,
   output logic                  last
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign last    = (cnt_q == CNT_W'(DATA_WIDTH - 1));
   assign bit_out = shreg_q[0];
   assign word    = word_q;

   always_comb begin
      word_d  = word_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load) begin
         word_d  = din;
         shreg_d = din;
         cnt_d   = '0;
      end else if (shift) begin
         shreg_d = shreg_q >> 1;
         cnt_d   = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         word_q  <= word_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// One CLK cycle per bit; TX_OUT/Busy are registered one cycle behind the FSM.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic     CLK,
   input  logic     RST,
   uart_tx_if.slave tx_if
);

   tx_state_e             state_q, state_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  load, shift;
   logic [DATA_WIDTH-1:0] word;
   logic                  data_bit, last_bit, par_bit;

   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .clk     (CLK),
      .rst     (RST),
      .load    (load),
      .shift   (shift),
      .din     (tx_if.P_DATA),
      .word    (word),
      .bit_out (data_bit),
      .last    (last_bit)
   );

   assign par_bit = (par_typ_q == PAR_ODD) ? ~(^word) : (^word);

   // Outputs are computed from the current state and registered, so the line
   // shows each state's bit one cycle after the FSM enters it.
   always_comb begin
      state_d   = state_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      load      = 1'b0;
      shift     = 1'b0;
      tx_d      = 1'b1;
      busy_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_if.DATA_VALID) begin
               load      = 1'b1;
               par_en_d  = tx_if.PAR_EN;
               par_typ_d = tx_if.PAR_TYP;
               state_d   = START;
            end
         end
         START: begin
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            tx_d   = data_bit;
            busy_d = 1'b1;
            shift  = 1'b1;
            if (last_bit) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            tx_d    = par_bit;
            busy_d  = 1'b1;
            state_d = STOP;
         end
         STOP: begin
            tx_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign tx_if.TX_OUT = tx_q;
   assign tx_if.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame table, corner-case sequences
// and random frames compared against a bit-list frame model.
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   uart_tx_if #(.DATA_WIDTH(8)) tx_if ();

   uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK   (clk),
      .RST   (rst),
      .tx_if (tx_if.slave)
   );

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   // Frame as a list of line levels, position 0 = start bit.
   function automatic logic [10:0] build(input logic [7:0] d, input logic en, input logic p);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (en) f[9] = p;
      return f;
   endfunction

   // Parity by counting ones: even parity bit makes the total count even.
   function automatic logic model_par(input logic [7:0] d, input logic typ);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return logic'(ones % 2) ^ typ;
   endfunction

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk({tag, "_idle_tx"}, tx_if.TX_OUT, 1'b1);
      chk({tag, "_idle_busy"}, tx_if.Busy, 1'b0);
   endtask

   // Called at a negedge; request is sampled on the following posedge.
   task automatic run_frame(input logic [7:0] d, input logic en, input logic typ,
                            input logic [10:0] f, input int len, input int glitch_at,
                            input string tag);
      tx_if.P_DATA     = d;
      tx_if.PAR_EN     = en;
      tx_if.PAR_TYP    = typ;
      tx_if.DATA_VALID = 1'b1;
      @(negedge clk);
      tx_if.DATA_VALID = 1'b0;
      tx_if.P_DATA     = 8'($urandom);
      tx_if.PAR_EN     = 1'($urandom);
      tx_if.PAR_TYP    = 1'($urandom);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         chk($sformatf("%s_bit%0d", tag, i), tx_if.TX_OUT, f[i]);
         chk($sformatf("%s_busy%0d", tag, i), tx_if.Busy, 1'b1);
         if (i == glitch_at) begin
            tx_if.DATA_VALID = 1'b1;
            tx_if.P_DATA     = 8'h3C;
         end else begin
            tx_if.DATA_VALID = 1'b0;
         end
      end
      idle_chk(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [10:0] f;
      logic [7:0]  d;
      logic        en, typ;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
      vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 11};
      vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 11};
      vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};

      rst              = 1'b1;
      tx_if.DATA_VALID = 1'b0;
      tx_if.P_DATA     = '0;
      tx_if.PAR_EN     = 1'b0;
      tx_if.PAR_TYP    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", tx_if.TX_OUT, 1'b1);
         chk("rst_busy", tx_if.Busy, 1'b0);
      end
      rst = 1'b0;
      repeat (5) idle_chk("post_rst");

      for (int i = 0; i < 7; i++)
         run_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ,
                   build(vecs[i].data, vecs[i].par_en, vecs[i].exp_par),
                   vecs[i].exp_len, -1, $sformatf("vec%0d", i));

      // Request during an in-flight frame must be dropped, not queued.
      run_frame(8'hFF, 1'b0, 1'b0, build(8'hFF, 1'b0, 1'b0), 10, 3, "ignore");
      repeat (12) idle_chk("ignore_after");

      // DATA_VALID held high: new frame accepted every 11 cycles.
      f = build(8'h11, 1'b0, 1'b0);
      tx_if.P_DATA     = 8'h11;
      tx_if.PAR_EN     = 1'b0;
      tx_if.DATA_VALID = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 33; j++) begin
         @(negedge clk);
         if (j % 11 < 10) begin
            chk($sformatf("b2b_bit%0d", j), tx_if.TX_OUT, f[j % 11]);
            chk($sformatf("b2b_busy%0d", j), tx_if.Busy, 1'b1);
         end else begin
            chk($sformatf("b2b_gap_tx%0d", j), tx_if.TX_OUT, 1'b1);
            chk($sformatf("b2b_gap_busy%0d", j), tx_if.Busy, 1'b0);
         end
         if (j == 31) tx_if.DATA_VALID = 1'b0;
      end
      idle_chk("b2b_end");

      // Reset while data bit 3 is on the line, with a request in the same cycle.
      f = build(8'hC3, 1'b0, 1'b0);
      tx_if.P_DATA     = 8'hC3;
      tx_if.PAR_EN     = 1'b0;
      tx_if.DATA_VALID = 1'b1;
      @(negedge clk);
      tx_if.DATA_VALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("pre_rst_bit%0d", i), tx_if.TX_OUT, f[i]);
      end
      rst              = 1'b1;
      tx_if.DATA_VALID = 1'b1;
      tx_if.P_DATA     = 8'h5A;
      @(negedge clk);
      chk("midrst_tx", tx_if.TX_OUT, 1'b1);
      chk("midrst_busy", tx_if.Busy, 1'b0);
      rst              = 1'b0;
      tx_if.DATA_VALID = 1'b0;
      idle_chk("midrst_after");
      run_frame(8'h5A, 1'b1, 1'b0, build(8'h5A, 1'b1, model_par(8'h5A, 1'b0)), 11, -1, "after_rst");

      for (int r = 0; r < 20; r++) begin
         d   = 8'($urandom);
         en  = 1'($urandom);
         typ = 1'($urandom);
         run_frame(d, en, typ, build(d, en, model_par(d, typ)), en ? 11 : 10, -1,
                   $sformatf("rnd%0d", r));
         repeat ($urandom_range(0, 3)) idle_chk("rnd_gap");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
